// File: rtl/mem_byte_loader.sv
// Byte-stream loader: parses framed bytes, assembles big-endian words and writes
// them into data memory while holding the core.
module mem_byte_loader #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid_in,
  output logic                  byte_ready_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  mem_wr_en_out,
  output logic                  core_hold_out,
  output logic                  done_out,
  output logic                  err_out,
  output logic [15:0]           words_written_out
);

  typedef enum logic [2:0] {IDLE, ADDR, CNT, DATA, WRITE, CHK, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [1:0]              idx_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg, last_addr_reg;
  logic [DATA_WIDTH-1:0]   word_reg, last_data_reg;
  logic [7:0]              cnt_hi_reg;
  logic [15:0]             remaining_reg;
  logic [15:0]             words_reg;
  logic [7:0]              csum_reg;
  logic                    err_reg;
  logic                    accept;
  logic                    in_write;

  assign in_write = (state_reg == WRITE);
  assign accept   = byte_valid_in && byte_ready_out;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next     = state_reg;
    byte_ready_out = 1'b0;
    core_hold_out  = 1'b0;
    done_out       = 1'b0;
    mem_wr_en_out  = 1'b0;
    case (state_reg)
      IDLE: begin
        byte_ready_out = 1'b1;
        if (byte_valid_in && byte_in == SYNC_BYTE) state_next = ADDR;
      end
      ADDR: begin
        byte_ready_out = 1'b1;
        core_hold_out  = 1'b1;
        if (byte_valid_in && idx_reg == 2'd3)
          state_next = (byte_in[1:0] != 2'b00) ? IDLE : CNT;
      end
      CNT: begin
        byte_ready_out = 1'b1;
        core_hold_out  = 1'b1;
        if (byte_valid_in && idx_reg[0])
          state_next = ({cnt_hi_reg, byte_in} == 16'd0) ? CHK : DATA;
      end
      DATA: begin
        byte_ready_out = 1'b1;
        core_hold_out  = 1'b1;
        if (byte_valid_in && idx_reg == 2'd3) state_next = WRITE;
      end
      WRITE: begin
        core_hold_out = 1'b1;
        mem_wr_en_out = 1'b1;
        state_next    = (remaining_reg == 16'd1) ? CHK : DATA;
      end
      CHK: begin
        byte_ready_out = 1'b1;
        core_hold_out  = 1'b1;
        if (byte_valid_in) state_next = DONE;
      end
      DONE: begin
        core_hold_out = 1'b1;
        done_out      = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Reset forces every strobe and handshake low before the state register clears.
    if (rst) begin
      byte_ready_out = 1'b0;
      core_hold_out  = 1'b0;
      done_out       = 1'b0;
      mem_wr_en_out  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg       <= 2'd0;
      addr_reg      <= '0;
      last_addr_reg <= '0;
      word_reg      <= '0;
      last_data_reg <= '0;
      cnt_hi_reg    <= 8'd0;
      remaining_reg <= 16'd0;
      words_reg     <= 16'd0;
      csum_reg      <= 8'd0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept && byte_in == SYNC_BYTE) begin
            idx_reg   <= 2'd0;
            words_reg <= 16'd0;
            csum_reg  <= 8'd0;
            err_reg   <= 1'b0;
          end
        end
        ADDR: begin
          if (accept) begin
            addr_reg <= {addr_reg[ADDR_WIDTH-9:0], byte_in};
            idx_reg  <= idx_reg + 2'd1;
            if (idx_reg == 2'd3 && byte_in[1:0] != 2'b00) err_reg <= 1'b1;
          end
        end
        CNT: begin
          if (accept) begin
            cnt_hi_reg    <= byte_in;
            remaining_reg <= {cnt_hi_reg, byte_in};
            idx_reg       <= {1'b0, ~idx_reg[0]};
          end
        end
        DATA: begin
          if (accept) begin
            word_reg <= {word_reg[DATA_WIDTH-9:0], byte_in};
            csum_reg <= csum_reg ^ byte_in;
            idx_reg  <= idx_reg + 2'd1;
          end
        end
        WRITE: begin
          last_addr_reg <= addr_reg;
          last_data_reg <= word_reg;
          addr_reg      <= addr_reg + ADDR_WIDTH'(4);
          words_reg     <= words_reg + 16'd1;
          remaining_reg <= remaining_reg - 16'd1;
        end
        CHK: begin
          if (accept && byte_in != csum_reg) err_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The write port shows the live word only during WRITE and holds it afterwards.
  assign addr_out          = in_write ? addr_reg : last_addr_reg;
  assign data_out          = in_write ? word_reg : last_data_reg;
  assign err_out           = err_reg;
  assign words_written_out = words_reg;

endmodule

// File: tb/tb_mem_byte_loader.sv
// Scoreboard bench for mem_byte_loader: expected writes and frame ends are queued
// by the stimulus and consumed by a negedge monitor.
module tb_mem_byte_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid_in;
  logic        byte_ready_out;
  logic [31:0] addr_out;
  logic [31:0] data_out;
  logic        mem_wr_en_out;
  logic        core_hold_out;
  logic        done_out;
  logic        err_out;
  logic [15:0] words_written_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] wr_q[$];    // {addr, data}
  logic [16:0] done_q[$];  // {err, words}
  logic        prev_wr = 1'b0;

  mem_byte_loader dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid_in(byte_valid_in),
    .byte_ready_out(byte_ready_out), .addr_out(addr_out), .data_out(data_out),
    .mem_wr_en_out(mem_wr_en_out), .core_hold_out(core_hold_out),
    .done_out(done_out), .err_out(err_out), .words_written_out(words_written_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Waits for ready with a bounded budget, then completes one handshake.
  task automatic send(input logic [7:0] b, input int gap);
    logic r;
    int   budget;
    byte_valid_in = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
    byte_in       = b;
    byte_valid_in = 1'b1;
    budget        = 0;
    forever begin
      @(negedge clk);
      r = byte_ready_out;
      @(posedge clk);
      if (r) break;
      budget++;
      if (budget > 20) begin
        check("ready_timeout", 64'd0, 64'd1);
        break;
      end
    end
    #1 byte_valid_in = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] addr, input logic [31:0] words[],
                            input logic [7:0] cks, input logic exp_err, input int max_gap);
    logic [7:0]  c;
    logic [31:0] a;
    logic [15:0] n;
    n = 16'(words.size());
    a = addr;
    send(8'hA5, 0);
    check("hold_after_sync", 64'(core_hold_out), 64'd1);
    check("err_cleared_by_sync", 64'(err_out), 64'd0);
    for (int i = 3; i >= 0; i--) begin
      c = addr[i*8 +: 8];
      send(c, $urandom_range(0, max_gap));
    end
    send(n[15:8], $urandom_range(0, max_gap));
    send(n[7:0], $urandom_range(0, max_gap));
    for (int w = 0; w < words.size(); w++) begin
      wr_q.push_back({a, words[w]});
      a = a + 32'd4;
      for (int i = 3; i >= 0; i--) begin
        c = words[w][i*8 +: 8];
        send(c, $urandom_range(0, max_gap));
      end
    end
    done_q.push_back({exp_err, n});
    send(cks, $urandom_range(0, max_gap));
  endtask

  // Monitor: compares every write and done pulse against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wr_en_out) begin
        check("wr_single_cycle", 64'(prev_wr), 64'd0);
        check("ready_low_on_write", 64'(byte_ready_out), 64'd0);
        if (wr_q.size() == 0) check("unexpected_write", 64'd1, 64'd0);
        else check("write_addr_data", {addr_out, data_out}, wr_q.pop_front());
      end else if (done_out) begin
        check("ready_low_on_done", 64'(byte_ready_out), 64'd0);
        check("hold_on_done", 64'(core_hold_out), 64'd1);
        if (done_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
        else check("done_err_words", {47'd0, err_out, words_written_out}, 64'(done_q.pop_front()));
      end else begin
        check("ready_high", 64'(byte_ready_out), 64'd1);
      end
      prev_wr <= mem_wr_en_out;
    end else begin
      prev_wr <= 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w2[], w3[], w1[], w0[];
    w2 = '{32'h11223344, 32'h55667788};
    w3 = '{32'h01020304, 32'hA0B0C0D0, 32'h0F0E0D0C};
    w1 = '{32'hDEADBEEF};
    w0 = new[0];

    rst = 1'b1; byte_valid_in = 1'b0; byte_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(byte_ready_out), 64'd0);
    check("rst_outputs", {addr_out, data_out}, 64'd0);
    check("rst_flags", {mem_wr_en_out, core_hold_out, done_out, err_out, words_written_out}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", 64'(byte_ready_out), 64'd1);

    // Good two-word frame.
    send_frame(32'h0000_0100, w2, 8'h88, 1'b0, 0);
    repeat (2) @(posedge clk); #1;
    check("hold_idle_after_frame", 64'(core_hold_out), 64'd0);
    check("words_after_frame", 64'(words_written_out), 64'd2);

    // Same frame, bad checksum: writes still happen, error persists.
    send_frame(32'h0000_0100, w2, 8'h00, 1'b1, 0);
    repeat (5) @(posedge clk); #1;
    check("err_sticky", 64'(err_out), 64'd1);

    // Misaligned address aborts after the 4th address byte.
    send(8'hA5, 0);
    check("err_cleared_on_sync", 64'(err_out), 64'd0);
    send(8'h00, 0); send(8'h00, 0); send(8'h01, 0); send(8'h02, 0);
    check("misalign_err", 64'(err_out), 64'd1);
    check("misalign_hold", 64'(core_hold_out), 64'd0);
    check("misalign_words", 64'(words_written_out), 64'd0);
    send(8'h00, 0); send(8'h02, 0);
    check("discard_hold", 64'(core_hold_out), 64'd0);

    // Leading garbage then an empty frame.
    send(8'h00, 0); send(8'hFF, 0); send(8'hA4, 0);
    check("garbage_hold", 64'(core_hold_out), 64'd0);
    send_frame(32'h0000_0200, w0, 8'h00, 1'b0, 0);
    repeat (2) @(posedge clk); #1;
    check("empty_frame_hold", 64'(core_hold_out), 64'd0);

    // Three words with random gaps, address wraps past the top.
    send_frame(32'hFFFF_FFF8, w3, 8'h04, 1'b0, 3);
    repeat (3) @(posedge clk); #1;

    // Reset in the middle of a word.
    send(8'hA5, 0);
    send(8'h00, 0); send(8'h00, 0); send(8'h03, 0); send(8'h00, 0);
    send(8'h00, 0); send(8'h01, 0);
    send(8'hCA, 0); send(8'hFE, 0);
    rst = 1'b1;
    #1;
    check("midrst_ready", 64'(byte_ready_out), 64'd0);
    check("midrst_strobes", {mem_wr_en_out, core_hold_out, done_out}, 64'd0);
    @(posedge clk); #1;
    check("midrst_outputs", {addr_out, data_out}, 64'd0);
    check("midrst_flags", {err_out, words_written_out}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_midrst", 64'(byte_ready_out), 64'd1);

    send_frame(32'h0000_0400, w1, 8'h22, 1'b0, 1);
    repeat (5) @(posedge clk); #1;
    check("wr_queue_empty", 64'(wr_q.size()), 64'd0);
    check("done_queue_empty", 64'(done_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
